bench_bist_ctrl: RTL



---
 rtl/bist_pkg.sv | 28 ++
 rtl/bist_misr.sv | 36 +++
 rtl/bench_bist_ctrl.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types, constants and helpers for the BIST controller family.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  // Galois feedback taps of the 32-bit pattern generator.
  localparam logic [31:0] LFSR_MASK         = 32'h8020_0003;
  localparam logic [7:0]  DEFAULT_MISR_POLY = 8'h85;
  localparam int          PAT_CNT_W         = 16;
  // Widest CUT input the pattern expander can feed.
  localparam int          PRPG_MAX_W        = 1024;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_MASK : 32'h0);
  endfunction

  // Replicates the LFSR word across the pattern, copy 0 in bits [31:0];
  // callers truncate to their CUT input width.
  function automatic logic [PRPG_MAX_W-1:0] prpg_expand(input logic [31:0] lfsr);
    return {(PRPG_MAX_W / 32){lfsr}};
  endfunction

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: clear has priority over enable.
module bist_misr
  import bist_pkg::*;
#(
  parameter int           W    = 108,
  parameter logic [W-1:0] POLY = W'(DEFAULT_MISR_POLY)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] sig
);

  logic [W-1:0] sig_q, sig_d;

  // Next signature: clear, shift-with-feedback plus data, or hold.
  always_comb begin
    sig_d = sig_q;
    if (clr) begin
      sig_d = '0;
    end else if (en) begin
      sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_in;
    end
  end

  // Signature register.
  always_ff @(posedge clk) begin
    if (!rst_n) sig_q <= '0;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/bench_bist_ctrl.sv
// BIST driver/compactor for one combinational benchmark CUT.
// Optional abort support is compiled in with BIST_ABORT_EN.
module bench_bist_ctrl
  import bist_pkg::*;
#(
  parameter int               IN_W         = 207,
  parameter int               OUT_W        = 108,
  parameter int               NUM_PATTERNS = 1024,
  parameter int               CUT_LAT      = 0,
  parameter logic [31:0]      LFSR_SEED    = 32'hACE1_0001,
  parameter logic [OUT_W-1:0] MISR_POLY    = OUT_W'(DEFAULT_MISR_POLY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [OUT_W-1:0]     golden_sig,
  output logic [IN_W-1:0]      cut_in,
  input  logic [OUT_W-1:0]     cut_out,
`ifdef BIST_ABORT_EN
  input  logic                 abort,
  output logic                 aborted,
`endif
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [OUT_W-1:0]     signature,
  output logic [PAT_CNT_W-1:0] pat_count
);

  // A zero seed would lock the LFSR at zero.
  localparam logic [31:0]          SEED_EFF   = (LFSR_SEED == 32'h0) ? 32'h1 : LFSR_SEED;
  localparam logic [PAT_CNT_W-1:0] LAST_PAT   = PAT_CNT_W'(NUM_PATTERNS);
  localparam logic [2:0]           DRAIN_LAST = (CUT_LAT > 0) ? 3'(CUT_LAT - 1) : 3'd0;

  bist_state_e            state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [IN_W-1:0]        cut_in_q, cut_in_d;
  logic [PAT_CNT_W-1:0]   pat_cnt_q, pat_cnt_d;
  logic [CUT_LAT:0]       vpipe_q, vpipe_d;
  logic [2:0]             drain_q, drain_d;
  logic                   done_q, done_d;
  logic                   issue, capture, misr_clr;
`ifdef BIST_ABORT_EN
  logic                   aborted_q, aborted_d;
`endif

  // Sequencing: pattern issue, capture qualification and state transitions.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    cut_in_d  = cut_in_q;
    pat_cnt_d = pat_cnt_q;
    drain_d   = drain_q;
    issue     = 1'b0;
    misr_clr  = 1'b0;
    // Responses are only meaningful while a run is in flight.
    capture   = vpipe_q[CUT_LAT] && (state_q == RUN || state_q == DRAIN);
`ifdef BIST_ABORT_EN
    aborted_d = aborted_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          misr_clr  = 1'b1;
          lfsr_d    = SEED_EFF;
          pat_cnt_d = PAT_CNT_W'(1);
          issue     = 1'b1;
`ifdef BIST_ABORT_EN
          aborted_d = 1'b0;
`endif
        end
      end
      RUN: begin
        if (pat_cnt_q == LAST_PAT) begin
          state_d = (CUT_LAT > 0) ? DRAIN : DONE;
          drain_d = DRAIN_LAST;
        end else begin
          lfsr_d    = lfsr_step(lfsr_q);
          pat_cnt_d = pat_cnt_q + PAT_CNT_W'(1);
          issue     = 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == 3'd0) state_d = DONE;
        else                 drain_d = drain_q - 3'd1;
      end
      default: state_d = IDLE;
    endcase
`ifdef BIST_ABORT_EN
    // Abort freezes the signature and drops everything still in flight.
    if (abort && (state_q == RUN || state_q == DRAIN)) begin
      state_d   = IDLE;
      lfsr_d    = lfsr_q;
      pat_cnt_d = pat_cnt_q;
      drain_d   = drain_q;
      issue     = 1'b0;
      capture   = 1'b0;
      aborted_d = 1'b1;
    end
`endif
    if (issue) cut_in_d = IN_W'(prpg_expand(lfsr_d));
    vpipe_d[0] = issue;
    for (int i = 1; i <= CUT_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
`ifdef BIST_ABORT_EN
    if (aborted_d && !aborted_q) vpipe_d = '0;
`endif
    done_d = (state_d == DONE) && (state_q != DONE);
  end

  // Control and pattern registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED_EFF;
      cut_in_q  <= '0;
      pat_cnt_q <= '0;
      vpipe_q   <= '0;
      drain_q   <= '0;
      done_q    <= 1'b0;
`ifdef BIST_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      cut_in_q  <= cut_in_d;
      pat_cnt_q <= pat_cnt_d;
      vpipe_q   <= vpipe_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
`ifdef BIST_ABORT_EN
      aborted_q <= aborted_d;
`endif
    end
  end

  bist_misr #(
    .W    (OUT_W),
    .POLY (MISR_POLY)
  ) u_misr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (misr_clr),
    .en      (capture),
    .data_in (cut_out),
    .sig     (signature)
  );

  assign cut_in    = cut_in_q;
  assign pat_count = pat_cnt_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign pass      = (state_q == DONE) && (signature == golden_sig);
`ifdef BIST_ABORT_EN
  assign aborted   = aborted_q;
`endif

endmodule
